// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC, applies NextInstrSel redirects, issues in-order
// instruction-memory requests and buffers returned words (with their PCs)
// for decode. Responses to requests in flight at a redirect are dropped.
module pc_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        NextInstrSel,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] JmpTarget,
  input  logic [ADDR_W-1:0] JmpRegTarget,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [SUM_W-1:0]  CREDITS = SUM_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  drop_cnt;

  // address queue: PCs of accepted requests; its count is the outstanding count
  logic [ADDR_W-1:0] aq_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  aq_wr, aq_rd;
  logic [CNT_W-1:0]  aq_cnt;

  // fetch buffer: {instruction, pc} pairs waiting for decode
  logic [DATA_W-1:0] fb_data [BUF_DEPTH];
  logic [ADDR_W-1:0] fb_pc   [BUF_DEPTH];
  logic [PTR_W-1:0]  fb_wr, fb_rd;
  logic [CNT_W-1:0]  fb_cnt;

  logic              redir, req_fire, rsp_pop, rsp_keep, dec_pop;
  logic [ADDR_W-1:0] tgt;
  logic [CNT_W-1:0]  drop_nxt;
  logic [SUM_W-1:0]  in_use;

  // redirect target select; code 00 is sequential and never used as a target
  always_comb begin
    tgt = pc;
    case (NextInstrSel)
      2'b01:   tgt = JmpTarget;
      2'b10:   tgt = JmpRegTarget;
      2'b11:   tgt = BranchTarget;
      default: tgt = pc;
    endcase
  end

  assign redir    = redirect_valid && (NextInstrSel != 2'b00);
  // every slot is either in flight or sitting in the buffer, so a response
  // always finds a free entry
  assign in_use   = SUM_W'(aq_cnt) + SUM_W'(fb_cnt);
  assign imem_req_valid = (state == FETCH) && !redir && (in_use < CREDITS);
  assign imem_addr      = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  // a stray response with nothing outstanding is ignored so the queue never underflows
  assign rsp_pop  = imem_rsp_valid && (aq_cnt != '0);
  assign rsp_keep = rsp_pop && (state == FETCH) && !redir;
  assign dec_pop  = instr_valid && instr_ready && !redir;
  // responses still owed after this cycle are all stale once we redirect
  assign drop_nxt = aq_cnt - CNT_W'(rsp_pop);

  assign instr_valid = (fb_cnt != '0);
  assign instr       = fb_data[fb_rd];
  assign instr_pc    = fb_pc[fb_rd];

  // control FSM: one idle cycle after reset, then fetch; drain stale responses after redirects
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      drop_cnt <= '0;
    end else if (redir) begin
      drop_cnt <= drop_nxt;
      state    <= (drop_nxt != '0) ? DRAIN : FETCH;
    end else begin
      case (state)
        IDLE:    state <= FETCH;
        DRAIN: begin
          if (rsp_pop) begin
            drop_cnt <= drop_cnt - CNT_ONE;
            if (drop_cnt == CNT_ONE) state <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // program counter: redirect wins, otherwise advance on each accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          pc <= RESET_PC;
    else if (redir)    pc <= {tgt[ADDR_W-1:2], 2'b00};
    else if (req_fire) pc <= pc + PC_STEP;
  end

  // address queue: push on request handshake, pop on every response (kept or dropped)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aq_wr  <= '0;
      aq_rd  <= '0;
      aq_cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) aq_mem[i] <= '0;
    end else begin
      if (req_fire) begin
        aq_mem[aq_wr] <= pc;
        aq_wr         <= aq_wr + PTR_ONE;
      end
      if (rsp_pop) aq_rd <= aq_rd + PTR_ONE;
      aq_cnt <= aq_cnt + CNT_W'(req_fire) - CNT_W'(rsp_pop);
    end
  end

  // fetch buffer: flushed on redirect, otherwise push kept responses and pop to decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_wr  <= '0;
      fb_rd  <= '0;
      fb_cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fb_data[i] <= '0;
        fb_pc[i]   <= '0;
      end
    end else if (redir) begin
      fb_wr  <= '0;
      fb_rd  <= '0;
      fb_cnt <= '0;
    end else begin
      if (rsp_keep) begin
        fb_data[fb_wr] <= imem_rsp_data;
        fb_pc[fb_wr]   <= aq_mem[aq_rd];
        fb_wr          <= fb_wr + PTR_ONE;
      end
      if (dec_pop) fb_rd <= fb_rd + PTR_ONE;
      fb_cnt <= fb_cnt + CNT_W'(rsp_keep) - CNT_W'(dec_pop);
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the next-instruction-select path: owns the program counter, applies the 2-bit NextInstrSel redirect code, and drives in-order requests to instruction memory.
- Buffers returned instructions with their PCs and hands them to decode over a valid/ready handshake.
- Discards responses to requests that were in flight when a redirect occurs.
- Sits between the control unit / EX redirect logic and the decode stage.

Parameters:
ADDR_W, 32, PC and target width
DATA_W, 32, instruction width
RESET_PC, 0, PC value after reset (low 2 bits must be 0)
BUF_DEPTH, 2, fetch-buffer entries; also the max outstanding requests (power of 2, ≥2)

Ports:
clk  in  1  clock, all flops rising edge
rst  in  1  asynchronous, active-low reset
NextInstrSel  in  2  00 seq, 01 jump, 10 jump-register, 11 branch taken
redirect_valid  in  1  qualifies NextInstrSel this cycle
JmpTarget  in  ADDR_W  target used for 01
JmpRegTarget  in  ADDR_W  target used for 10
BranchTarget  in  ADDR_W  target used for 11
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  ADDR_W  request address (= PC)
imem_rsp_valid  in  1  response valid, one per accepted request, in order, ≥1 cycle later
imem_rsp_data  in  DATA_W  instruction word
instr_valid  out  1  buffer non-empty
instr_ready  in  1  decode accepts
instr  out  DATA_W  head instruction
instr_pc  out  ADDR_W  PC of head instruction

Behaviour:
- Reset (rst=0, asynchronous): PC=RESET_PC; imem_req_valid=0; imem_addr=RESET_PC; instr_valid=0; instr=0; instr_pc=0; buffer, address queue and counters cleared; FSM=IDLE.
- FSM states:
  - IDLE: exactly one cycle after reset release, then FETCH.
  - FETCH: normal operation.
  - DRAIN: drop_cnt>0.
- Credit rule: imem_req_valid=1 only in FETCH, with no redirect this cycle, and only when outstanding + buffer occupancy < BUF_DEPTH.
- imem_addr=PC at all times.
- On handshake (valid&&ready):
  - PC ← PC+4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0).
  - The request PC is pushed to the address queue.
  - outstanding increments.
- Response in FETCH:
  - {imem_rsp_data, popped queue PC} is written to the buffer.
  - outstanding decrements.
  - The credit rule guarantees a free entry.
- Decode side:
  - Pop on instr_valid&&instr_ready.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
- Redirect (redirect_valid=1 and NextInstrSel≠00):
  - PC ← the selected target with bits[1:0] forced to 0.
  - Buffer cleared; any pop in that cycle is ignored.
  - No request is issued that cycle.
  - drop_cnt ← outstanding − imem_rsp_valid; a response arriving in the redirect cycle is discarded.
  - FSM → DRAIN if drop_cnt>0, otherwise FETCH.
  - The first request at the target is issued the next cycle at the earliest.
- redirect_valid=1 with NextInstrSel=00: no effect, counts as sequential.
- DRAIN:
  - No requests issued.
  - Each response is discarded, and drop_cnt and outstanding decrement with its queue entry.
  - At drop_cnt=0 → FETCH.
  - A redirect in DRAIN updates PC and recomputes drop_cnt by the same rule, staying in DRAIN while drop_cnt>0.
- Latency: request-to-instr_valid is the memory latency plus 1 cycle (registered buffer).
- Reset mid-operation: immediately returns all outputs to reset values. Responses arriving after reset release for pre-reset requests are a system error and are not handled.

Test Plan:
- Reset with RESET_PC=0x100, ready held 1, latency 1 → first imem_req_valid in the 2nd cycle after release, addr 0x100, then 0x104, 0x108; instr_pc follows 0x100, 0x104 with matching data.
- instr_ready=0, memory always ready → exactly 2 requests issued (0x0, 0x4), instr_valid=1 holding instr_pc 0x0; requests resume one cycle after instr_ready=1.
- Two requests outstanding (0x8, 0xC), branch redirect NextInstrSel=11 with BranchTarget=0x40 → both responses discarded, no requests during DRAIN, next request addr 0x40, next instr_pc 0x40.
- NextInstrSel=01 with JmpTarget=0x203 and zero outstanding → no DRAIN, next request addr 0x200, buffer flushed, instr_valid=0 the cycle after.
- Redirect in the same cycle as a response and a decode pop → response dropped, pop ignored, drop_cnt=outstanding−1, buffer empty.
- PC at 0xFFFFFFFC accepted → next addr 0x0. Then assert rst mid-fetch → imem_req_valid and instr_valid go to 0 asynchronously, PC=RESET_PC.
